// File: rtl/fft_pkg.sv
// fft_pkg: constants shared across the FFT datapath (complex multiplier,
// butterfly and scaling stages).
//   - default component widths for samples, twiddles and outputs
//   - the DROP derivation (LSBs discarded from a full-precision product)
//   - saturation limits for the default output width
//   - the rounding mode selected at build time by FFT_CMULT_CONV_ROUND_EN
package fft_pkg;

  localparam int FFT_IWIDTH = 18;
  localparam int FFT_CWIDTH = 18;
  localparam int FFT_OWIDTH = 18;

  // A full product carries iw+cw significant bits; keeping ow of them
  // means the remainder is shifted out.
  function automatic int fft_drop(input int iw, input int cw, input int ow);
    return iw + cw - ow;
  endfunction

  localparam int FFT_DROP = fft_drop(FFT_IWIDTH, FFT_CWIDTH, FFT_OWIDTH);

  localparam logic signed [FFT_OWIDTH-1:0] FFT_SAT_MAX = {1'b0, {(FFT_OWIDTH-1){1'b1}}};
  localparam logic signed [FFT_OWIDTH-1:0] FFT_SAT_MIN = {1'b1, {(FFT_OWIDTH-1){1'b0}}};

  typedef enum logic {
    FFT_ROUND_TRUNC,
    FFT_ROUND_CONV
  } fft_round_e;

`ifdef FFT_CMULT_CONV_ROUND_EN
  localparam fft_round_e FFT_ROUND_MODE = FFT_ROUND_CONV;
`else
  localparam fft_round_e FFT_ROUND_MODE = FFT_ROUND_TRUNC;
`endif

endpackage

// File: rtl/fft_round_sat.sv
// fft_round_sat: drops DROP LSBs from one signed component and saturates
// the result to OWIDTH bits.
// Build option: FFT_CMULT_CONV_ROUND_EN selects convergent rounding
// (round half to even); without it the LSBs are simply floored away
// (arithmetic shift right) and no rounding adder exists.
// Ports:
//   din  in  IN_W    full-precision signed value
//   dout out OWIDTH  rounded, saturated value
//   ovf  out 1       saturation occurred
module fft_round_sat #(
  parameter int IN_W   = 37,
  parameter int DROP   = 18,
  parameter int OWIDTH = 18
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [OWIDTH-1:0] dout,
  output logic                     ovf
);

  localparam int KW = IN_W - DROP;

  logic signed [KW-1:0] keep;
  assign keep = din[IN_W-1:DROP];

`ifdef FFT_CMULT_CONV_ROUND_EN
  // One extra bit so a round-up of the largest kept value cannot wrap;
  // it shows up as an overflow for the saturation stage instead.
  localparam int RW = KW + 1;
  localparam logic [DROP-1:0] HALF = DROP'(1) << (DROP - 1);

  logic [DROP-1:0]    frac;
  logic               round_up;
  logic signed [RW-1:0] rounded;

  assign frac     = din[DROP-1:0];
  // Ties go to the even neighbour so repeated rounding does not bias the FFT.
  assign round_up = (frac > HALF) || ((frac == HALF) && keep[0]);
  assign rounded  = RW'(keep) + RW'(round_up);
`else
  localparam int RW = KW;

  logic signed [RW-1:0] rounded;
  logic                 unused_frac;

  assign rounded     = keep;
  assign unused_frac = ^din[DROP-1:0];
`endif

  // Compare in a width that can hold both the rounded value and the
  // OWIDTH limits, so the limits never need to be truncated.
  localparam int CW = (RW > OWIDTH) ? RW : OWIDTH + 1;
  localparam logic signed [CW-1:0] MAX_E = {{(CW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_E = {{(CW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

  logic signed [CW-1:0] v_ext;
  assign v_ext = CW'(rounded);

  always_comb begin
    dout = v_ext[OWIDTH-1:0];
    ovf  = 1'b0;
    if (v_ext > MAX_E) begin
      dout = {1'b0, {(OWIDTH-1){1'b1}}};
      ovf  = 1'b1;
    end else if (v_ext < MIN_E) begin
      dout = {1'b1, {(OWIDTH-1){1'b0}}};
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/fft_cmult.sv
// fft_cmult: pipelined complex multiplier (sample x twiddle) using three
// real multipliers, with round/saturate to OWIDTH and valid/ready
// backpressure. Latency is 4 edges from acceptance to out_valid.
// Build option: FFT_CMULT_CONV_ROUND_EN (convergent rounding instead of
// truncation, see fft_round_sat); latency is the same either way.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake
//   a_re, a_im           sample, IWIDTH each
//   w_re, w_im           twiddle Q1.(CWIDTH-1), CWIDTH each
//   out_valid / out_ready output handshake
//   o_re, o_im           product, OWIDTH each
//   o_ovf                either component of this output saturated
module fft_cmult
  import fft_pkg::*;
#(
  parameter int IWIDTH = FFT_IWIDTH,
  parameter int CWIDTH = FFT_CWIDTH,
  parameter int OWIDTH = FFT_OWIDTH,
  parameter int DROP   = fft_drop(IWIDTH, CWIDTH, OWIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] a_re,
  input  logic signed [IWIDTH-1:0] a_im,
  input  logic signed [CWIDTH-1:0] w_re,
  input  logic signed [CWIDTH-1:0] w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] o_re,
  output logic signed [OWIDTH-1:0] o_im,
  output logic                     o_ovf
);

  localparam int AW = IWIDTH + 1;
  localparam int WW = CWIDTH + 1;
  localparam int PW = IWIDTH + CWIDTH + 1;

  // Stage S1 is two register ranks: the raw input capture (rank 0) and the
  // pre-adds (rank 1). S2 holds the products, S3 the post-adds, S4 the outputs.
  logic                     v0_q, v0_d;
  logic signed [IWIDTH-1:0] a_re0_q, a_re0_d, a_im0_q, a_im0_d;
  logic signed [CWIDTH-1:0] w_re0_q, w_re0_d, w_im0_q, w_im0_d;

  logic                     v1_q, v1_d;
  logic signed [IWIDTH-1:0] a_re1_q, a_re1_d, a_im1_q, a_im1_d;
  logic signed [CWIDTH-1:0] w_re1_q, w_re1_d;
  logic signed [AW-1:0]     sum_a1_q, sum_a1_d;
  logic signed [WW-1:0]     dif_w1_q, dif_w1_d, sum_w1_q, sum_w1_d;

  logic                     v2_q, v2_d;
  logic signed [PW-1:0]     k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;

  logic                     v3_q, v3_d;
  logic signed [PW-1:0]     re3_q, re3_d, im3_q, im3_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [OWIDTH-1:0] o_re_q, o_re_d, o_im_q, o_im_d;
  logic                     o_ovf_q, o_ovf_d;

  logic signed [OWIDTH-1:0] rs_re, rs_im;
  logic                     ovf_re, ovf_im;
  logic                     ce;

  // The whole pipe moves together; it only freezes when an output is
  // sitting there unclaimed. Bubbles travel as invalid ranks.
  assign ce       = !out_valid_q || out_ready;
  assign in_ready = ce;

  fft_round_sat #(.IN_W(PW), .DROP(DROP), .OWIDTH(OWIDTH)) u_rs_re (
    .din (re3_q),
    .dout(rs_re),
    .ovf (ovf_re)
  );

  fft_round_sat #(.IN_W(PW), .DROP(DROP), .OWIDTH(OWIDTH)) u_rs_im (
    .din (im3_q),
    .dout(rs_im),
    .ovf (ovf_im)
  );

  // Next-state for every rank: hold by default, shift when ce is high.
  // Gauss 3-multiply form: re = k1 - k3, im = k1 + k2, all full precision.
  always_comb begin
    v0_d = v0_q; a_re0_d = a_re0_q; a_im0_d = a_im0_q;
    w_re0_d = w_re0_q; w_im0_d = w_im0_q;
    v1_d = v1_q; a_re1_d = a_re1_q; a_im1_d = a_im1_q; w_re1_d = w_re1_q;
    sum_a1_d = sum_a1_q; dif_w1_d = dif_w1_q; sum_w1_d = sum_w1_q;
    v2_d = v2_q; k1_d = k1_q; k2_d = k2_q; k3_d = k3_q;
    v3_d = v3_q; re3_d = re3_q; im3_d = im3_q;
    out_valid_d = out_valid_q; o_re_d = o_re_q; o_im_d = o_im_q; o_ovf_d = o_ovf_q;
    if (ce) begin
      v0_d    = in_valid;
      a_re0_d = a_re;
      a_im0_d = a_im;
      w_re0_d = w_re;
      w_im0_d = w_im;

      v1_d     = v0_q;
      a_re1_d  = a_re0_q;
      a_im1_d  = a_im0_q;
      w_re1_d  = w_re0_q;
      sum_a1_d = AW'(a_re0_q) + AW'(a_im0_q);
      dif_w1_d = WW'(w_im0_q) - WW'(w_re0_q);
      sum_w1_d = WW'(w_re0_q) + WW'(w_im0_q);

      v2_d = v1_q;
      k1_d = PW'(w_re1_q) * PW'(sum_a1_q);
      k2_d = PW'(a_re1_q) * PW'(dif_w1_q);
      k3_d = PW'(a_im1_q) * PW'(sum_w1_q);

      v3_d  = v2_q;
      re3_d = k1_q - k3_q;
      im3_d = k1_q + k2_q;

      out_valid_d = v3_q;
      o_re_d      = rs_re;
      o_im_d      = rs_im;
      o_ovf_d     = ovf_re | ovf_im;
    end
  end

  // Control and output registers: reset empties the pipe and zeroes outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      o_re_q      <= '0;
      o_im_q      <= '0;
      o_ovf_q     <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_valid_q <= out_valid_d;
      o_re_q      <= o_re_d;
      o_im_q      <= o_im_d;
      o_ovf_q     <= o_ovf_d;
    end
  end

  // Internal datapath registers carry no reset; their valids guard them.
  always_ff @(posedge clk) begin
    a_re0_q  <= a_re0_d;
    a_im0_q  <= a_im0_d;
    w_re0_q  <= w_re0_d;
    w_im0_q  <= w_im0_d;
    a_re1_q  <= a_re1_d;
    a_im1_q  <= a_im1_d;
    w_re1_q  <= w_re1_d;
    sum_a1_q <= sum_a1_d;
    dif_w1_q <= dif_w1_d;
    sum_w1_q <= sum_w1_d;
    k1_q     <= k1_d;
    k2_q     <= k2_d;
    k3_q     <= k3_d;
    re3_q    <= re3_d;
    im3_q    <= im3_d;
  end

  assign out_valid = out_valid_q;
  assign o_re      = o_re_q;
  assign o_im      = o_im_q;
  assign o_ovf     = o_ovf_q;

endmodule

// File: tb/tb_fft_cmult.sv
// tb_fft_cmult: self-checking bench for fft_cmult at default widths.
// A reference model computes each expected product straight from the
// complex arithmetic (4-multiply form, then floor or round-half-even,
// then saturate) and queues it on acceptance; a negedge monitor pops and
// compares on every output transfer and checks stall stability.
// Honors FFT_CMULT_CONV_ROUND_EN the same way as the design.
module tb_fft_cmult;

  localparam int IW   = 18;
  localparam int CWD  = 18;
  localparam int OW   = 18;
  localparam int DROP = IW + CWD - OW;
  localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW - 1));

  typedef struct {
    longint re;
    longint im;
    bit     ovf;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [IW-1:0]  a_re, a_im;
  logic signed [CWD-1:0] w_re, w_im;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [OW-1:0]  o_re, o_im;
  logic                  o_ovf;

  int   checks = 0;
  int   errors = 0;
  int   outs_seen = 0;
  bit   rand_ready = 1'b0;
  exp_t sb[$];
  exp_t e;
  bit   prev_stall = 1'b0;
  logic signed [OW-1:0] prev_re, prev_im;
  logic prev_ovf;

  fft_cmult dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_re     (a_re),
    .a_im     (a_im),
    .w_re     (w_re),
    .w_im     (w_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o_re     (o_re),
    .o_im     (o_im),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint round_drop(input longint full);
    longint q;
`ifdef FFT_CMULT_CONV_ROUND_EN
    longint rem, half;
`endif
    q = full >>> DROP;
`ifdef FFT_CMULT_CONV_ROUND_EN
    rem  = full - (q <<< DROP);
    half = 64'sd1 <<< (DROP - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
    return q;
  endfunction

  function automatic exp_t model(input longint ar, input longint ai,
                                 input longint wr, input longint wi);
    exp_t r;
    r.re  = round_drop(ar * wr - ai * wi);
    r.im  = round_drop(ar * wi + ai * wr);
    r.ovf = 1'b0;
    if (r.re > MAXV) begin r.re = MAXV; r.ovf = 1'b1; end
    if (r.re < MINV) begin r.re = MINV; r.ovf = 1'b1; end
    if (r.im > MAXV) begin r.im = MAXV; r.ovf = 1'b1; end
    if (r.im < MINV) begin r.im = MINV; r.ovf = 1'b1; end
    return r;
  endfunction

  function automatic int rnd18();
    logic signed [17:0] x;
    int sel;
    sel = $urandom_range(0, 9);
    x   = 18'($urandom);
    if (sel == 0) return -131072;
    if (sel == 1) return 131071;
    return int'(x);
  endfunction

  // Negedge monitor: scoreboard, stall stability, in_ready rule.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_re", o_re, prev_re);
        check("stall_im", o_im, prev_im);
        check("stall_ovf", o_ovf, prev_ovf);
      end
      if (out_valid && out_ready) begin
        outs_seen++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: actual re=%0d im=%0d required none", o_re, o_im);
        end else begin
          e = sb.pop_front();
          check("model_re", o_re, e.re);
          check("model_im", o_im, e.im);
          check("model_ovf", o_ovf, e.ovf);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a_re, a_im, w_re, w_im));
      prev_stall = out_valid && !out_ready;
      prev_re    = o_re;
      prev_im    = o_im;
      prev_ovf   = o_ovf;
    end
  end

  // Downstream readiness: always ready unless random backpressure is on.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? (($urandom % 3) != 0) : 1'b1;
  end

  task automatic applyStimulus(input int ar, input int ai, input int wr, input int wi);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a_re = IW'(ar); a_im = IW'(ai); w_re = CWD'(wr); w_im = CWD'(wi);
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("accept_timeout", guard, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int exp_re, input int exp_im,
                             input bit exp_ovf);
    int cycles;
    cycles = 0;
    while (cycles < 13) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid) break;
    end
    check({name, "_latency"}, cycles, 4);
    check({name, "_re"}, o_re, exp_re);
    check({name, "_im"}, o_im, exp_im);
    check({name, "_ovf"}, o_ovf, exp_ovf);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent, guard, start_outs;
    bit acc, ghost;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; w_re = '0; w_im = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_o_re", o_re, 0);
    check("reset_o_im", o_im, 0);
    check("reset_o_ovf", o_ovf, 0);
    check("reset_in_ready", in_ready, 1);

    applyStimulus(1000, -2000, 65536, 0);
    checkOutput("scale_quarter", 250, -500, 1'b0);
    applyStimulus(1000, 1000, 0, 65536);
    checkOutput("rot90", -250, 250, 1'b0);
    applyStimulus(-131072, -131072, -131072, -131072);
    checkOutput("saturate", 0, 131071, 1'b1);
`ifdef FFT_CMULT_CONV_ROUND_EN
    applyStimulus(3, 0, 65536, 0); checkOutput("round_3", 1, 0, 1'b0);
    applyStimulus(2, 0, 65536, 0); checkOutput("round_2", 0, 0, 1'b0);
    applyStimulus(6, 0, 65536, 0); checkOutput("round_6", 2, 0, 1'b0);
`else
    applyStimulus(3, 0, 65536, 0); checkOutput("trunc_3", 0, 0, 1'b0);
    applyStimulus(2, 0, 65536, 0); checkOutput("trunc_2", 0, 0, 1'b0);
    applyStimulus(6, 0, 65536, 0); checkOutput("trunc_6", 1, 0, 1'b0);
`endif
    repeat (3) @(posedge clk);
    #1;

    // Random stream under pseudo-random backpressure.
    $display("[TB] random stream with backpressure");
    start_outs = outs_seen;
    rand_ready = 1'b1;
    sent = 0; guard = 0;
    while (sent < 20 && guard < 2000) begin
      in_valid = (($urandom % 4) != 0);
      a_re = IW'(rnd18()); a_im = IW'(rnd18());
      w_re = CWD'(rnd18()); w_im = CWD'(rnd18());
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, 20);
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("stream_drained", sb.size(), 0);
    check("stream_count", outs_seen - start_outs, 20);
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset with three samples in flight plus one presented during reset.
    $display("[TB] reset mid-stream");
    in_valid = 1'b1;
    a_re = 500; a_im = 0; w_re = 65536; w_im = 0;
    @(posedge clk); #1;
    a_re = 1200; a_im = 400;
    @(posedge clk); #1;
    a_re = -800; a_im = 900;
    @(posedge clk); #1;
    rst = 1'b1;
    a_re = 7000; a_im = 7000; w_re = 65536; w_im = 65536;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_o_re", o_re, 0);
    check("midreset_o_im", o_im, 0);
    check("midreset_o_ovf", o_ovf, 0);
    check("midreset_in_ready", in_ready, 1);
    ghost = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) ghost = 1'b1;
    end
    check("midreset_no_ghost", ghost, 0);
    applyStimulus(1000, -2000, 65536, 0);
    checkOutput("post_reset", 250, -500, 1'b0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_cmult.md
# fft_cmult

Pipelined, parametrised complex multiplier for the FFT datapath. It multiplies a complex sample by a complex twiddle factor using three real multipliers. The result is rounded and saturated to a configurable output width, and a valid/ready handshake with full backpressure carries samples through. It replaces the single real 18x18 twiddle multiplier and sits between the butterfly add stage and the next FFT stage's input buffer.

## Interface
- IWIDTH, 18: sample component width, signed two's complement.
- CWIDTH, 18: twiddle component width, signed, Q1.(CWIDTH-1).
- OWIDTH, 18: output component width, signed.
- DROP, IWIDTH+CWIDTH-OWIDTH: LSBs discarded from the full product; must be >= 1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts input this cycle.
- a_re, a_im  in  IWIDTH each  sample.
- w_re, w_im  in  CWIDTH each  twiddle.
- out_valid  out  1  output sample present.
- out_ready  in  1  downstream accepts output.
- o_re, o_im  out  OWIDTH each  product.
- o_ovf  out  1  set when either component of this output saturated.

## Operation
- Computes (a_re + j·a_im)(w_re + j·w_im) with 3 multiplies:
  - k1 = w_re·(a_re + a_im)
  - k2 = a_re·(w_im − w_re)
  - k3 = a_im·(w_re + w_im)
  - re = k1 − k3, im = k1 + k2
- Internal widths are full precision:
  - pre-adds are one bit wider than their operands;
  - products and post-adds are IWIDTH+CWIDTH+1 bits.
  - No intermediate truncation is allowed.
- Output conversion: round off DROP LSBs (see Configuration). The result is IWIDTH+CWIDTH+1−DROP bits, saturated to OWIDTH. Positive overflow gives 2^(OWIDTH−1)−1; negative overflow gives −2^(OWIDTH−1).
- o_ovf = saturation occurred on re OR im for that sample.
- Pipeline has 4 stages:
  - S1: register inputs and form pre-adds.
  - S2: the three products.
  - S3: post-adds.
  - S4: round/saturate into the output registers.
- Each stage has its own valid bit.
- Advance enable ce = !out_valid || out_ready. When ce=0 all stages, including the S1 capture, hold.
- in_ready = ce. This is combinational from out_ready and out_valid only.
- Transfers occur on in_valid && in_ready and on out_valid && out_ready.
- Bubbles propagate as invalid stages; they are not squeezed out.

## Timing
- Latency is 4 cycles: a sample accepted at edge N is presented with out_valid=1 after edge N+4, provided ce stayed 1.
- Each cycle of ce=0 adds one cycle of latency.
- Throughput is 1 sample/cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - o_re, o_im and o_ovf are stable;
  - in_ready=0;
  - no sample is lost or duplicated.
- Reset:
  - all stage valids clear;
  - out_valid=0, o_re=0, o_im=0, o_ovf=0;
  - in_ready=1 during the cycle after reset.
- Reset mid-stream discards all in-flight samples. Input presented during the reset cycle is not captured.
- Datapath registers other than the outputs need no reset.
- Simultaneous output handshake and new input is legal every cycle.

## Configuration
- FFT_CMULT_CONV_ROUND_EN defined: convergent rounding (round half to even) on the DROP LSBs. This rounding is applied before saturation, and a round-up that overflows saturates and sets o_ovf.
- Undefined: truncation (floor, arithmetic shift right by DROP). The rounding adder is absent.
- Latency is identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - the default width constants;
  - the DROP derivation;
  - the saturation limit constants, for reuse by the butterfly and scaling stages.
- One sub-module, fft_round_sat (parametrised input width, DROP, OWIDTH), does rounding and saturation for one component and outputs the value plus an overflow bit.
- fft_cmult instantiates fft_round_sat twice in S4.

## Test plan
Defaults apply throughout.
- a=(1000,−2000), w=(65536,0) → (250,−500), o_ovf=0, out_valid exactly 4 cycles after acceptance.
- a=(1000,1000), w=(0,65536) → (−250,250).
- a=(−131072,−131072), w=(−131072,−131072) → re=0, im saturates to 131071, o_ovf=1.
- Rounding, a=(3,0)/(2,0)/(6,0), w=(65536,0):
  - with macro → 1/0/2;
  - without → 0/0/1.
- Stream of 20 random samples with out_ready toggled pseudo-randomly → outputs match the reference model in order, no drops or duplicates, outputs stable while stalled.
- rst asserted for one cycle with 3 samples in flight → out_valid=0 and outputs 0 next cycle. None of the 3 samples ever appear. The next accepted sample emerges after 4 cycles.
